keypad_digit_collector: RTL and testbench
=========================================

# keypad_digit_collector

Accumulates decoded keypad presses into a 20-digit BCD buffer and delivers each completed entry as one `senhaPac_t` word with a single-cycle valid strobe. Sits directly upstream of the setup and password-check stages, driving their `digitos_value` and `digitos_valid` inputs. It also drives a live echo of the last six typed digits for the display mux.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: inactivity window in clk cycles. Only used when the timeout feature is compiled in.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: collector active. Low means keys are ignored and the buffer is held empty.
- `key_value` input 4: decoded key.
  - 0x0–0x9: digits.
  - 0xA: `*`.
  - 0xB: `#`.
  - 0xC–0xF: invalid.
- `key_valid` input 1: one-cycle strobe per debounced key press.
- `digitos_value` output `senhaPac_t` (20×4 bits): last emitted entry. Index 0 is the most recent digit.
- `digitos_valid` output 1: one-cycle strobe marking a new `digitos_value`.
- `bcd_pac` output `bcdPac_t`: echo of the live buffer. BCD0 is the newest digit. Unused positions are 0xF.

## Operation
- Internal state:
  - Buffer `buf[0..19]` of 4-bit digits.
  - Digit count `cnt` (0..20, 5 bits).
  - FSM with states EMPTY, COLLECT, FULL.
- Digit key, EMPTY or COLLECT:
  - Shift: `buf[i] <= buf[i-1]` for i = 19..1, then `buf[0] <= key`.
  - `cnt` increments.
  - The FSM moves to COLLECT, or to FULL when `cnt` becomes 20.
- Digit key in FULL: ignored. The buffer is unchanged and the oldest digit is never dropped.
- `#` key:
  - Emit `digitos_value <= buf` and pulse `digitos_valid`.
  - Clear the buffer to all 0xF and set `cnt <= 0`. FSM goes to EMPTY.
  - Pressing `#` in EMPTY emits `{20{4'hF}}`, which downstream reads as "skip/keep current".
- `*` key: emit `{20{4'hB}}` ("save/exit") and pulse `digitos_valid`. Clear the buffer. FSM goes to EMPTY.
- Keys 0xC–0xF: ignored, with no state change.
- `enable` low:
  - `key_valid` is ignored.
  - The buffer clears to 0xF, `cnt` to 0, and the FSM to EMPTY on the next edge.
  - `digitos_value` holds its last value.
- `bcd_pac.BCDk = buf[k]` for k = 0..5. It is a registered copy, so it updates in the same cycle as the buffer.
- `digitos_value` holds between strobes. Downstream may sample it on any cycle where `digitos_valid` is high.

## Timing
- Reset values:
  - `digitos_value = {20{4'hF}}`, `digitos_valid = 0`.
  - `bcd_pac` all 0xF.
  - Buffer all 0xF, `cnt = 0`, FSM in EMPTY.
- Key strobe on edge N: the buffer, `bcd_pac`, `digitos_value` and `digitos_valid` all update at edge N+1, so latency is 1 cycle.
- `digitos_valid` is high for exactly one cycle per `#` or `*`, never two cycles in a row.
  - Consecutive strobes require consecutive `key_valid` pulses.
  - Back-to-back `#`,`#` on edges N and N+1 gives pulses at N+1 and N+2. The second carries `{20{F}}`.
- When `enable` falls in the same cycle as `key_valid`, `enable` wins: the key is dropped and nothing is emitted.
- Reset asserted mid-entry:
  - Outputs return to reset values immediately, because the reset is asynchronous.
  - No partial emission occurs.
  - A `digitos_valid` pulse in flight is cut short.

## Configuration
- `KEYPAD_TIMEOUT_EN` defined:
  - A 32-bit inactivity counter reloads on every accepted `key_valid` (digit, `#` or `*`) and counts only when `cnt > 0`.
  - When it reaches `TIMEOUT_CYCLES - 1`, the buffer clears, `cnt` goes to 0 and the FSM goes to EMPTY. Nothing is emitted.
  - If a key and expiry fall in the same cycle, the key wins and the counter reloads.
  - Invalid keys do not reload the counter.
- `KEYPAD_TIMEOUT_EN` undefined: no counter exists, and the buffer persists until `#`, `*`, `enable` low or reset.

## Test plan
- Reset, then keys 1,2,3,4,`#`: exactly one `digitos_valid` pulse. `digitos_value` is `{16{F}},1,2,3,4`, i.e. `[0]=4`, `[3]=1`. Afterwards `bcd_pac` returns to all 0xF.
- `#` with an empty buffer: a pulse with `{20{F}}`. Then `*`: a pulse with `{20{B}}`. The strobes are non-overlapping.
- 22 digit keys (0..9 repeating), then `#`: only the first 20 are captured, so `[0]=9` (the 20th key) and `[19]=0`. Keys 21–22 are ignored.
- Keys 7, 0xC, 5: `bcd_pac.BCD0=5`, `BCD1=7`. The invalid key leaves no trace.
- `enable` dropped after keys 8,8, then raised, then `#`: emits `{20{F}}`.
- With `KEYPAD_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`:
  - Key 3 followed by 16 idle cycles clears the buffer with no strobe, and a following `#` emits `{20{F}}`.
  - Key 3, then 15 idle cycles, then key 4 keeps both digits.

Source files
------------

// File: rtl/keypad_digit_collector.sv
// keypad_digit_collector
//
// Collects decoded keypad digits into a 20-digit BCD buffer and hands each
// completed entry downstream as one senhaPac_t word with a one-cycle strobe.
//   '#' emits the buffer (all 0xF when nothing was typed).
//   '*' emits all 0xB ("save/exit").
// Both keys clear the buffer. Digits typed once the buffer holds 20 are
// ignored, so the oldest digit is never dropped.
//
// Optional feature (compile-time macro KEYPAD_TIMEOUT_EN):
//   Clears a partial entry after TIMEOUT_CYCLES clk cycles without an
//   accepted key. Nothing is emitted when this happens.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-high reset
//   enable        in   collector active; low drops keys and empties buffer
//   key_value     in   decoded key: 0-9 digit, A '*', B '#', C-F invalid
//   key_valid     in   one-cycle strobe per debounced key press
//   digitos_value out  last emitted entry, index 0 = most recent digit
//   digitos_valid out  one-cycle strobe marking a new digitos_value
//   bcd_pac       out  echo of the six newest buffered digits (BCD0 newest)

package keypad_pkg;
    typedef logic [19:0][3:0] senhaPac_t;
    typedef struct packed {
        logic [3:0] BCD5;
        logic [3:0] BCD4;
        logic [3:0] BCD3;
        logic [3:0] BCD2;
        logic [3:0] BCD1;
        logic [3:0] BCD0;
    } bcdPac_t;
endpackage

module keypad_digit_collector
    import keypad_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] key_value,
    input  logic       key_valid,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid,
    output bcdPac_t    bcd_pac
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    logic [1:0] state_q, state_d;
    senhaPac_t  buf_q, buf_d;
    logic [4:0] cnt_q, cnt_d;
    senhaPac_t  value_d;
    logic       valid_d;

    logic is_digit;
    logic is_hash;
    logic is_star;
    logic expire;

    assign is_digit = key_valid && (key_value <= 4'd9);
    assign is_hash  = key_valid && (key_value == KEY_HASH);
    assign is_star  = key_valid && (key_value == KEY_STAR);

`ifdef KEYPAD_TIMEOUT_EN
    logic [31:0] idle_q;

    // Only a partial entry can expire; an empty buffer never counts.
    assign expire = (cnt_q != 5'd0) && (idle_q == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else if (enable && (is_digit || is_hash || is_star)) begin
            idle_q <= '0;
        end else if (expire) begin
            idle_q <= '0;
        end else if (cnt_q != 5'd0) begin
            idle_q <= idle_q + 32'd1;
        end
    end
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Priority: enable low, then '#', '*', digit, then inactivity expiry.
    // A key in the expiry cycle therefore wins over the timeout.
    always_comb begin
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        value_d = digitos_value;
        valid_d = 1'b0;

        if (!enable) begin
            buf_d   = '1;
            cnt_d   = '0;
            state_d = ST_EMPTY;
        end else if (is_hash) begin
            value_d = buf_q;
            valid_d = 1'b1;
            buf_d   = '1;
            cnt_d   = '0;
            state_d = ST_EMPTY;
        end else if (is_star) begin
            value_d = {20{KEY_HASH}};
            valid_d = 1'b1;
            buf_d   = '1;
            cnt_d   = '0;
            state_d = ST_EMPTY;
        end else if (is_digit) begin
            if (state_q != ST_FULL) begin
                buf_d   = {buf_q[18:0], key_value};
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd19) ? ST_FULL : ST_COLLECT;
            end
        end else if (expire) begin
            buf_d   = '1;
            cnt_d   = '0;
            state_d = ST_EMPTY;
        end
    end

    // bcd_pac is loaded from the next buffer value so the echo changes on
    // the same edge as the buffer itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            buf_q         <= '1;
            cnt_q         <= '0;
            digitos_value <= '1;
            digitos_valid <= 1'b0;
            bcd_pac       <= '1;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            digitos_value <= value_d;
            digitos_valid <= valid_d;
            bcd_pac       <= bcdPac_t'(buf_d[5:0]);
        end
    end

endmodule

// File: tb/tb_keypad_digit_collector.sv
// Self-checking bench for keypad_digit_collector: a constant vector table,
// hand-written multi-cycle sequences and randomized keys checked against a
// queue-based reference model. Timeout cases run only with KEYPAD_TIMEOUT_EN.

module tb_keypad_digit_collector;
    import keypad_pkg::*;

    localparam int unsigned TO_CYCLES = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] key_value = 4'h0;
    logic       key_valid = 1'b0;
    senhaPac_t  digitos_value;
    logic       digitos_valid;
    bcdPac_t    bcd_pac;

    keypad_digit_collector #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .key_value     (key_value),
        .key_valid     (key_valid),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid),
        .bcd_pac       (bcd_pac)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: q[0] is the newest digit, at most 20 kept.
    logic [3:0]  q[$];
    logic [79:0] m_val   = {20{4'hF}};
    logic        m_valid = 1'b0;
    int          idle    = 0;

    localparam logic [79:0] ALL_F = {20{4'hF}};
    localparam logic [79:0] ALL_B = {20{4'hB}};

    function automatic logic [79:0] m_entry();
        logic [79:0] r;
        for (int i = 0; i < 20; i++)
            r[i*4 +: 4] = (i < q.size()) ? q[i] : 4'hF;
        return r;
    endfunction

    function automatic logic [23:0] m_bcd();
        logic [23:0] r;
        for (int i = 0; i < 6; i++)
            r[i*4 +: 4] = (i < q.size()) ? q[i] : 4'hF;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_val   = ALL_F;
        m_valid = 1'b0;
        idle    = 0;
    endtask

    task automatic model_update(input bit en, input bit kv, input logic [3:0] key);
        m_valid = 1'b0;
        if (!en) begin
            q.delete();
        end else if (kv && key <= 4'd9) begin
            if (q.size() < 20) q.push_front(key);
            idle = 0;
        end else if (kv && key == 4'hB) begin
            m_val   = m_entry();
            m_valid = 1'b1;
            q.delete();
            idle = 0;
        end else if (kv && key == 4'hA) begin
            m_val   = ALL_B;
            m_valid = 1'b1;
            q.delete();
            idle = 0;
        end else begin
`ifdef KEYPAD_TIMEOUT_EN
            if (q.size() > 0) begin
                idle++;
                if (idle == TO_CYCLES) begin
                    q.delete();
                    idle = 0;
                end
            end
`endif
        end
    endtask

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, " valid"}, 80'(digitos_valid), 80'(m_valid));
        check({tag, " value"}, digitos_value, m_val);
        check({tag, " bcd"}, 80'(bcd_pac), 80'(m_bcd()));
    endtask

    // One clock: drive on the falling edge, check 1 time unit after rising.
    task automatic step(input bit en, input bit kv, input logic [3:0] key, input string tag);
        @(negedge clk);
        enable    = en;
        key_valid = kv;
        key_value = key;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        model_update(en, kv, key);
        compare_model(tag);
    endtask

    typedef struct {
        bit          en;
        bit          kv;
        logic [3:0]  key;
        bit          exp_valid;
        logic [79:0] exp_value;
        logic [23:0] exp_bcd;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{1, 1, 4'h1, 0, ALL_F, 24'hFFFFF1};
        vecs[1]  = '{1, 1, 4'h2, 0, ALL_F, 24'hFFFF12};
        vecs[2]  = '{1, 1, 4'h3, 0, ALL_F, 24'hFFF123};
        vecs[3]  = '{1, 1, 4'h4, 0, ALL_F, 24'hFF1234};
        vecs[4]  = '{1, 1, 4'hB, 1, 80'hFFFFFFFFFFFFFFFF1234, 24'hFFFFFF};
        vecs[5]  = '{1, 0, 4'h0, 0, 80'hFFFFFFFFFFFFFFFF1234, 24'hFFFFFF};
        vecs[6]  = '{1, 1, 4'hB, 1, ALL_F, 24'hFFFFFF};
        vecs[7]  = '{1, 1, 4'hA, 1, ALL_B, 24'hFFFFFF};
        vecs[8]  = '{1, 0, 4'h0, 0, ALL_B, 24'hFFFFFF};
        vecs[9]  = '{1, 1, 4'h7, 0, ALL_B, 24'hFFFFF7};
        vecs[10] = '{1, 1, 4'hC, 0, ALL_B, 24'hFFFFF7};
        vecs[11] = '{1, 1, 4'h5, 0, ALL_B, 24'hFFFF75};
        vecs[12] = '{1, 1, 4'h8, 0, ALL_B, 24'hFFF758};
        vecs[13] = '{0, 1, 4'h8, 0, ALL_B, 24'hFFFFFF};
        vecs[14] = '{1, 1, 4'hB, 1, ALL_F, 24'hFFFFFF};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset valid", 80'(digitos_valid), 80'd0);
        check("reset value", digitos_value, ALL_F);
        check("reset bcd", 80'(bcd_pac), 80'hFFFFFF);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        model_reset();

        // Vector table
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].en, vecs[i].kv, vecs[i].key, $sformatf("tbl%0d model", i));
            check($sformatf("tbl%0d valid", i), 80'(digitos_valid), 80'(vecs[i].exp_valid));
            check($sformatf("tbl%0d value", i), digitos_value, vecs[i].exp_value);
            check($sformatf("tbl%0d bcd", i), 80'(bcd_pac), 80'(vecs[i].exp_bcd));
        end

        // Enable low then raised after 8,8 then '#': empty entry
        step(1, 1, 4'h8, "en88 a");
        step(1, 1, 4'h8, "en88 b");
        step(0, 0, 4'h0, "en88 low");
        step(1, 0, 4'h0, "en88 high");
        step(1, 1, 4'hB, "en88 hash");
        check("en88 valid", 80'(digitos_valid), 80'd1);
        check("en88 value", digitos_value, ALL_F);

        // Back-to-back '#','#': second pulse carries all F
        step(1, 1, 4'h6, "b2b digit");
        step(1, 1, 4'hB, "b2b hash1");
        check("b2b first", digitos_value, 80'hFFFFFFFFFFFFFFFFFFF6);
        step(1, 1, 4'hB, "b2b hash2");
        check("b2b second valid", 80'(digitos_valid), 80'd1);
        check("b2b second value", digitos_value, ALL_F);
        step(1, 0, 4'h0, "b2b idle");
        check("b2b drop", 80'(digitos_valid), 80'd0);

        // 22 digits: only the first 20 kept
        for (int i = 0; i < 22; i++)
            step(1, 1, 4'(i % 10), $sformatf("full%0d", i));
        step(1, 1, 4'hB, "full hash");
        check("full [0]", 80'(digitos_value[0]), 80'h9);
        check("full [19]", 80'(digitos_value[19]), 80'h0);
        check("full value", digitos_value, 80'h01234567890123456789);

`ifdef KEYPAD_TIMEOUT_EN
        // Key 3 then 16 idle cycles: silently cleared
        step(1, 1, 4'h3, "to key");
        for (int i = 0; i < 15; i++) step(1, 0, 4'h0, "to idle");
        check("to kept", 80'(bcd_pac), 80'hFFFFF3);
        step(1, 0, 4'h0, "to expire");
        check("to cleared", 80'(bcd_pac), 80'hFFFFFF);
        check("to no strobe", 80'(digitos_valid), 80'd0);
        step(1, 1, 4'hB, "to hash");
        check("to hash value", digitos_value, ALL_F);
        // Key 3, 15 idle, key 4: both kept
        step(1, 1, 4'h3, "to2 key3");
        for (int i = 0; i < 15; i++) step(1, 0, 4'h0, "to2 idle");
        step(1, 1, 4'h4, "to2 key4");
        check("to2 bcd", 80'(bcd_pac), 80'hFFFF34);
        step(1, 1, 4'hB, "to2 hash");
`endif

        // Asynchronous reset while a strobe is in flight
        step(1, 1, 4'h1, "rst digit");
        step(1, 1, 4'hB, "rst hash");
        rst = 1'b1;
        #1;
        check("rst cut valid", 80'(digitos_valid), 80'd0);
        check("rst cut value", digitos_value, ALL_F);
        check("rst cut bcd", 80'(bcd_pac), 80'hFFFFFF);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomized keys against the model
        for (int i = 0; i < 800; i++) begin
            int unsigned r;
            bit en;
            bit kv;
            logic [3:0] key;
            r  = $urandom_range(0, 99);
            en = ($urandom_range(0, 19) != 0);
            kv = ($urandom_range(0, 3) != 0);
            if (r < 75)      key = 4'($urandom_range(0, 9));
            else if (r < 83) key = 4'hB;
            else if (r < 88) key = 4'hA;
            else             key = 4'($urandom_range(12, 15));
            step(en, kv, key, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
